// File: rtl/sdp_fifo_ctrl.sv
// FIFO controller for an external simple dual-port RAM with 1-cycle registered read and a 2-entry FWFT output stage.
// Define SDP_FIFO_CTRL_ALMOST_EN to add registered almost_full/almost_empty flags (AF_THR/AE_THR).
module sdp_fifo_ctrl #(
    parameter int DW    = 8,
    parameter int WORDS = 256
`ifdef SDP_FIFO_CTRL_ALMOST_EN
    ,
    parameter int AF_THR = WORDS - 2,
    parameter int AE_THR = 2
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DW-1:0]              in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DW-1:0]              out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(WORDS)-1:0]   ram_waddr,
    output logic                       ram_we,
    output logic [DW-1:0]              ram_wdata,
    output logic [$clog2(WORDS)-1:0]   ram_raddr,
    input  logic [DW-1:0]              ram_rdata,
    output logic [$clog2(WORDS+3)-1:0] level
`ifdef SDP_FIFO_CTRL_ALMOST_EN
    ,
    output logic                       almost_full,
    output logic                       almost_empty
`endif
);
    localparam int AW = $clog2(WORDS);
    localparam int CW = $clog2(WORDS + 1);
    localparam int LW = $clog2(WORDS + 3);
    localparam logic [CW-1:0] MEM_FULL = CW'(WORDS);

    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] mem_cnt_q, mem_cnt_d;
    logic          inflight_q, inflight_d;
    logic [1:0]    stg_cnt_q, stg_cnt_d, stg_left, stg_busy;
    logic [DW-1:0] head_q, head_d, skid_q, skid_d;
    logic [LW-1:0] level_q, level_d;
    logic          push, pop, issue;

    // Input side: RAM write port driven straight from the stream
    assign in_ready  = rst_n & (mem_cnt_q < MEM_FULL);
    assign push      = in_valid & in_ready;
    assign ram_we    = push;
    assign ram_waddr = wptr_q;
    assign ram_wdata = in_data;

    // Read issue: keep staged + in-flight words at most 2 so a capture always has a free slot
    assign out_valid = (stg_cnt_q != 2'd0);
    assign pop       = out_valid & out_ready;
    assign stg_left  = stg_cnt_q - {1'b0, pop};
    assign stg_busy  = stg_left + {1'b0, inflight_q};
    assign issue     = (mem_cnt_q != '0) & (stg_busy < 2'd2);
    assign ram_raddr = rptr_q;

    assign inflight_d = issue;
    assign stg_cnt_d  = stg_busy;

    always_comb begin
        mem_cnt_d = mem_cnt_q;
        if (push && !issue) begin
            mem_cnt_d = mem_cnt_q + CW'(1);
        end else if (!push && issue) begin
            mem_cnt_d = mem_cnt_q - CW'(1);
        end
    end

    // Output stage: pop shifts skid to head, then the captured word fills the first free slot
    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        if (pop) begin
            head_d = skid_q;
        end
        if (inflight_q) begin
            if (stg_left == 2'd0) begin
                head_d = ram_rdata;
            end else begin
                skid_d = ram_rdata;
            end
        end
    end

    assign level_d  = LW'(mem_cnt_d) + LW'(inflight_d) + LW'(stg_cnt_d);
    assign level    = level_q;
    assign out_data = head_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            mem_cnt_q  <= '0;
            inflight_q <= 1'b0;
            stg_cnt_q  <= 2'd0;
            head_q     <= '0;
            skid_q     <= '0;
            level_q    <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (issue) begin
                rptr_q <= rptr_q + AW'(1);
            end
            mem_cnt_q  <= mem_cnt_d;
            inflight_q <= inflight_d;
            stg_cnt_q  <= stg_cnt_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            level_q    <= level_d;
        end
    end

`ifdef SDP_FIFO_CTRL_ALMOST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (level_d >= LW'(AF_THR));
            almost_empty <= (level_d <= LW'(AE_THR));
        end
    end
`endif

endmodule

// File: tb/tb_sdp_fifo_ctrl.sv
// Bench for sdp_fifo_ctrl (WORDS=4, DW=8) with a 1-cycle registered dual-port RAM model and a data scoreboard.
module tb_sdp_fifo_ctrl;
    localparam int DW    = 8;
    localparam int WORDS = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    ram_waddr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [1:0]    ram_raddr;
    logic [DW-1:0] ram_rdata;
    logic [2:0]    level;
`ifdef SDP_FIFO_CTRL_ALMOST_EN
    logic          almost_full;
    logic          almost_empty;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] sb_q[$];
    int            occ;
    int            pop_cnt = 0;
    int            wr_total;
    int            rd_iss;
    logic [1:0]    wptr_m;
    logic [1:0]    prev_raddr;

    always #5 clk = ~clk;

`ifdef SDP_FIFO_CTRL_ALMOST_EN
    sdp_fifo_ctrl #(.DW(DW), .WORDS(WORDS), .AF_THR(5), .AE_THR(1)) dut (
`else
    sdp_fifo_ctrl #(.DW(DW), .WORDS(WORDS)) dut (
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ram_waddr (ram_waddr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata),
        .level     (level)
`ifdef SDP_FIFO_CTRL_ALMOST_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    logic [DW-1:0] ram_mem [WORDS];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_waddr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_raddr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor samples mid-cycle; inputs change just after posedge
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            occ        = 0;
            wr_total   = 0;
            rd_iss     = 0;
            wptr_m     = 2'd0;
            prev_raddr = 2'd0;
        end else begin
            if (ram_raddr != prev_raddr) rd_iss++;
            prev_raddr = ram_raddr;
            check("level", 32'(level), 32'(occ));
            check("ram_we", 32'(ram_we), 32'(in_valid & in_ready));
            check("write_ram_full", 32'(ram_we && (wr_total - rd_iss == WORDS)), 32'd0);
            if (occ <= 3) check("in_ready_room", 32'(in_ready), 32'd1);
            if (occ == 6) check("in_ready_full", 32'(in_ready), 32'd0);
`ifdef SDP_FIFO_CTRL_ALMOST_EN
            check("almost_full", 32'(almost_full), 32'(occ >= 5));
            check("almost_empty", 32'(almost_empty), 32'(occ <= 1));
`endif
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("pop_unexpected", 32'(out_valid), 32'd0);
                end else begin
                    check("data", 32'(out_data), 32'(sb_q.pop_front()));
                    occ--;
                end
                pop_cnt++;
            end
            if (ram_we) begin
                check("waddr", 32'(ram_waddr), 32'(wptr_m));
                check("wdata", 32'(ram_wdata), 32'(in_data));
                sb_q.push_back(in_data);
                occ++;
                wr_total++;
                wptr_m = wptr_m + 2'd1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_errors %0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int sent;
        int c;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        cyc(3);
        rst_n = 1'b1;
        cyc(1);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_level", 32'(level), 32'd0);

        // Single word latency
        in_valid = 1'b1; in_data = 8'h11;
        cyc(1);
        in_valid = 1'b0;
        check("t2_valid_n", 32'(out_valid), 32'd0);
        cyc(1);
        check("t2_valid_n1", 32'(out_valid), 32'd0);
        cyc(1);
        check("t2_valid_n2", 32'(out_valid), 32'd1);
        check("t2_data", 32'(out_data), 32'h11);
        check("t2_level", 32'(level), 32'd1);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        check("t2_drained_valid", 32'(out_valid), 32'd0);
        check("t2_drained_level", 32'(level), 32'd0);

        // Fill to capacity with the output blocked
        for (int v = 1; v <= 6; v++) begin
            in_valid = 1'b1; in_data = 8'(v);
            check("t3_accept", 32'(in_ready), 32'd1);
            cyc(1);
        end
        in_data = 8'h07;
        check("t3_full", 32'(in_ready), 32'd0);
        check("t3_level", 32'(level), 32'd6);
        cyc(3);
        check("t3_stall", 32'(in_ready), 32'd0);
        check("t3_level_hold", 32'(level), 32'd6);
        check("t3_head", 32'(out_data), 32'h01);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int v = 1; v <= 6; v++) begin
            check("t3_drain_valid", 32'(out_valid), 32'd1);
            check("t3_drain_data", 32'(out_data), 32'(v));
            cyc(1);
        end
        out_ready = 1'b0;
        check("t3_empty_valid", 32'(out_valid), 32'd0);
        check("t3_empty_level", 32'(level), 32'd0);

        // Streaming at full rate across several pointer wraps
        out_ready = 1'b1;
        for (int k = 0; k < 23; k++) begin
            in_valid = (k < 20); in_data = 8'(k);
            if (k < 20) check("t4_in_ready", 32'(in_ready), 32'd1);
            if (k >= 3) begin
                check("t4_no_gap", 32'(out_valid), 32'd1);
                check("t4_data", 32'(out_data), 32'(k - 3));
            end
            cyc(1);
        end
        in_valid = 1'b0;
        check("t4_done_valid", 32'(out_valid), 32'd0);
        check("t4_done_level", 32'(level), 32'd0);

        // Random handshakes against the scoreboard
        base = pop_cnt; sent = 0; c = 0;
        while ((pop_cnt - base) < 1000 && c < 30000) begin
            in_valid  = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data   = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) sent++;
            cyc(1);
            c++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("t5_words_out", 32'(pop_cnt - base), 32'd1000);
        cyc(2);
        check("t5_final_level", 32'(level), 32'd0);

        // Reset in the middle of traffic discards everything at once
        for (int v = 0; v < 4; v++) begin
            in_valid = 1'b1; in_data = 8'(8'hC0 + v);
            cyc(1);
        end
        in_valid = 1'b0;
        cyc(3);
        check("t1_pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t1_async_valid", 32'(out_valid), 32'd0);
        check("t1_async_level", 32'(level), 32'd0);
        check("t1_async_data", 32'(out_data), 32'd0);
        check("t1_async_in_ready", 32'(in_ready), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(4);
        check("t1_post_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_data = 8'hA5;
        cyc(1);
        in_valid = 1'b0;
        cyc(2);
        check("t1_post_data", 32'(out_data), 32'hA5);
        out_ready = 1'b1;
        cyc(3);
        out_ready = 1'b0;
        check("t1_post_empty", 32'(level), 32'd0);
        check("t1_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sdp_fifo_ctrl.md
Name: sdp_fifo_ctrl

Overview:
Synchronous FIFO controller that drives an external simple dual-port RAM. The RAM has a write port A, a read port B, and a registered read with 1-cycle latency. The controller converts the RAM's address/data ports into valid/ready streams on the input and output sides. A small output prefetch stage gives first-word-fall-through and full throughput of 1 word/cycle, despite the read latency.

Parameters:
DW, 8, data width; must match the attached RAM.
WORDS, 256, RAM depth; power of 2, >= 2.
AF_THR, WORDS-2, almost-full threshold (only with optional feature).
AE_THR, 2, almost-empty threshold (only with optional feature).

Ports:
clk  in  1  system clock; all logic on posedge.
rst_n  in  1  asynchronous active-low reset.
in_data  in  DW  write stream data.
in_valid  in  1  write stream valid.
in_ready  out  1  write stream ready.
out_data  out  DW  read stream data (head of FIFO).
out_valid  out  1  read stream valid.
out_ready  in  1  read stream ready.
ram_waddr  out  $clog2(WORDS)  RAM port A address.
ram_we  out  1  RAM port A write enable.
ram_wdata  out  DW  RAM port A data.
ram_raddr  out  $clog2(WORDS)  RAM port B address.
ram_rdata  in  DW  RAM port B registered read data.
level  out  $clog2(WORDS+3)  total words held: RAM + in-flight + output stage.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). Reset clears wptr, rptr, mem_cnt, in-flight flag and output-stage count; out_valid=0, level=0, out_data=0.
- in_ready = rst_n & (mem_cnt < WORDS), combinational. While rst_n is low, in_ready=0.
- Write:
  - push = in_valid & in_ready.
  - ram_we=push, ram_waddr=wptr, ram_wdata=in_data, all combinational.
  - On push, wptr increments with wrap modulo WORDS.
- Read issue:
  - pop = out_valid & out_ready.
  - issue = (mem_cnt>0) & (stg_cnt + inflight - pop < 2).
  - ram_raddr = rptr, combinational. On issue, rptr increments with wrap and inflight<=1; otherwise inflight<=0.
- Capture: when inflight=1, ram_rdata is written into the output stage in that cycle.
- Output stage: 2-entry buffer (head + skid).
  - out_data = head; out_valid = (stg_cnt>0).
  - On pop, the skid entry moves to head. A captured word goes to the first free slot after the pop is applied.
- mem_cnt:
  - +1 on push only; -1 on issue only; unchanged when push and issue occur in the same cycle.
- level = mem_cnt + inflight + stg_cnt, registered, consistent with the other state every cycle.
- Latency: a word pushed into an empty FIFO at edge N is issued at N+1, captured at N+2, so out_valid=1 after edge N+2 (3 cycles). Sustained push+pop with out_ready=1 gives 1 word/cycle, no bubbles.
- Capacity: WORDS in RAM + 2 in output stage. in_ready depends only on mem_cnt, never on out_ready (no combinational ready path from output to input).
- Address collision: impossible. A read issues only when mem_cnt>0, and a write only when mem_cnt<WORDS, so in the same cycle raddr != waddr unless mem_cnt==WORDS, when no write occurs. Read-during-write RAM mode is therefore irrelevant.
- Data order is strictly FIFO across pointer wrap.
- in_valid with in_ready=0: no effect, no error. out_ready with out_valid=0: no effect.
- Reset mid-operation: all contents discarded immediately. RAM contents are not cleared but are unreachable.

Optional Feature:
Macro: SDP_FIFO_CTRL_ALMOST_EN
- Defined: adds outputs almost_full and almost_empty, both registered and reset to 0 and 1 respectively.
  - almost_full = (level_next >= AF_THR).
  - almost_empty = (level_next <= AE_THR).
  - Both update in the same cycle as level.
- Undefined: ports, parameters AF_THR/AE_THR logic and comparators are absent. All other behaviour is identical.

Test Plan:
Test setup for all scenarios: WORDS=4, DW=8, attached to a 1-cycle registered dual-port RAM model.
1. Reset release, idle -> in_ready=1, out_valid=0, level=0. Assert rst_n low mid-test -> out_valid and level go to 0 immediately (asynchronous).
2. Push 8'h11 once with out_ready=0 -> out_valid rises 2 edges after the push edge, out_data=8'h11, level=1.
3. Push 8'h01..8'h07 with out_ready=0 -> 6 words accepted (2 staged + 4 RAM), in_ready=0 after the 6th, level=6, 8'h07 stalls. Then out_ready=1 -> outputs 01..06 in order, one per cycle.
4. Continuous push 8'h00..8'h13 with out_ready=1 throughout -> after the initial latency, out_valid stays high and data emerges in order with no gaps. Pointers wrap 5 times with no corruption.
5. Random in_valid/out_ready, 50% each, 1000 words -> scoreboard order and content match. level equals the model occupancy every cycle; ram_we never fires with mem_cnt==4.
6. With SDP_FIFO_CTRL_ALMOST_EN, AF_THR=5, AE_THR=1 -> almost_full=1 exactly when level>=5; almost_empty=1 at level 0 and 1, 0 at level 2.
